// File: rtl/frame_reorder_buffer.sv
// ---------------------------------------------------------------------------
// frame_reorder_buffer
//
// Ping-pong frame buffer for a streaming datapath. Each accepted input sample
// is stored, optionally inverted, into the bank currently being written. The
// same accepting edge reads the opposite bank, which holds the previously
// completed frame. The read is either in order, which gives a fixed delay of
// DEPTH accepted samples, or time-reversed.
//
// Parameters
//   WIDTH   sample width in bits (>= 1)
//   DEPTH   samples per frame / entries per bank (>= 2, any value)
//   INVERT  1: store ~in_data, 0: store in_data unchanged
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous reset, active low
//   clear        synchronous clear, active high; wins over in_valid
//   mode         0: in-order delay, 1: frame reversal (latched at frame start)
//   in_valid     in_data is accepted on this rising edge
//   in_data      input sample
//   out_valid    out_data carries a new sample this cycle
//   out_data     registered output sample, held while out_valid is low
//   frame_start  the current output sample is element 0 of an output frame
// ---------------------------------------------------------------------------
module frame_reorder_buffer #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter bit INVERT = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             frame_start
);

  localparam int IDX_W = $clog2(DEPTH);
  // Wrap is detected by comparing against the last index rather than by
  // natural counter overflow, so non-power-of-2 depths never skip an index.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};

  // Storage: two banks of DEPTH samples each.
  logic [WIDTH-1:0] bank_r [2][DEPTH];

  // Control and output registers.
  logic [IDX_W-1:0] wr_idx_r;
  logic             wr_bank_r;
  logic             prev_full_r;
  logic             mode_q_r;
  logic             out_valid_r;
  logic             frame_start_r;
  logic [WIDTH-1:0] out_data_r;

  // Next-state values.
  logic [IDX_W-1:0] wr_idx_nx_s;
  logic             wr_bank_nx_s;
  logic             prev_full_nx_s;
  logic             mode_q_nx_s;
  logic             out_valid_nx_s;
  logic             frame_start_nx_s;
  logic [WIDTH-1:0] out_data_nx_s;

  // Datapath helpers.
  logic             mode_eff_s;
  logic [IDX_W-1:0] rd_idx_s;
  logic [WIDTH-1:0] store_data_s;
  logic             last_idx_s;

  // Effective mode, read index and value to store for the current sample.
  always_comb begin
    mode_eff_s   = mode_q_r;
    rd_idx_s     = wr_idx_r;
    store_data_s = in_data;
    last_idx_s   = (wr_idx_r == LAST_IDX);
    // The first sample of a frame uses the freshly presented mode; the rest
    // of the frame uses the value latched on that first sample.
    if (wr_idx_r == ZERO_IDX) begin
      mode_eff_s = mode;
    end else begin
      mode_eff_s = mode_q_r;
    end
    if (mode_eff_s) begin
      rd_idx_s = LAST_IDX - wr_idx_r;
    end else begin
      rd_idx_s = wr_idx_r;
    end
    if (INVERT) begin
      store_data_s = ~in_data;
    end else begin
      store_data_s = in_data;
    end
  end

  // Next-state logic for the write pointer, frame flags and output stage.
  always_comb begin
    wr_idx_nx_s      = wr_idx_r;
    wr_bank_nx_s     = wr_bank_r;
    prev_full_nx_s   = prev_full_r;
    mode_q_nx_s      = mode_q_r;
    out_valid_nx_s   = 1'b0;
    frame_start_nx_s = 1'b0;
    out_data_nx_s    = out_data_r;
    if (clear) begin
      wr_idx_nx_s    = ZERO_IDX;
      wr_bank_nx_s   = 1'b0;
      prev_full_nx_s = 1'b0;
      mode_q_nx_s    = 1'b0;
      out_data_nx_s  = {WIDTH{1'b0}};
    end else if (in_valid) begin
      mode_q_nx_s = mode_eff_s;
      // Reading the opposite bank means a same-edge read/write never collide.
      if (prev_full_r) begin
        out_valid_nx_s   = 1'b1;
        frame_start_nx_s = (wr_idx_r == ZERO_IDX);
        out_data_nx_s    = bank_r[~wr_bank_r][rd_idx_s];
      end else begin
        out_valid_nx_s   = 1'b0;
        frame_start_nx_s = 1'b0;
        out_data_nx_s    = out_data_r;
      end
      if (last_idx_s) begin
        wr_idx_nx_s    = ZERO_IDX;
        wr_bank_nx_s   = ~wr_bank_r;
        prev_full_nx_s = 1'b1;
      end else begin
        wr_idx_nx_s    = wr_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
        wr_bank_nx_s   = wr_bank_r;
        prev_full_nx_s = prev_full_r;
      end
    end else begin
      out_valid_nx_s   = 1'b0;
      frame_start_nx_s = 1'b0;
      out_data_nx_s    = out_data_r;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_idx_r      <= ZERO_IDX;
      wr_bank_r     <= 1'b0;
      prev_full_r   <= 1'b0;
      mode_q_r      <= 1'b0;
      out_valid_r   <= 1'b0;
      frame_start_r <= 1'b0;
      out_data_r    <= {WIDTH{1'b0}};
    end else begin
      wr_idx_r      <= wr_idx_nx_s;
      wr_bank_r     <= wr_bank_nx_s;
      prev_full_r   <= prev_full_nx_s;
      mode_q_r      <= mode_q_nx_s;
      out_valid_r   <= out_valid_nx_s;
      frame_start_r <= frame_start_nx_s;
      out_data_r    <= out_data_nx_s;
    end
  end

  // Bank storage: cleared on reset/clear, written at the current pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          bank_r[b][i] <= {WIDTH{1'b0}};
        end
      end
    end else if (clear) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          bank_r[b][i] <= {WIDTH{1'b0}};
        end
      end
    end else if (in_valid) begin
      bank_r[wr_bank_r][wr_idx_r] <= store_data_s;
    end
  end

  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_frame_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_frame_reorder_buffer
//
// Three instances share one stimulus stream: (DEPTH=4, INVERT=1),
// (DEPTH=4, INVERT=0) and (DEPTH=3, INVERT=1). A reference model keeps the
// full history of stored samples since the last reset/clear and derives every
// output from frame arithmetic. A vector table adds fixed expectations for
// the first instance.
// ---------------------------------------------------------------------------
module tb_frame_reorder_buffer;

  localparam int NI = 3;

  logic       clk;
  logic       reset_n;
  logic       clear;
  logic       mode;
  logic       in_valid;
  logic [7:0] in_data;

  logic       ov  [NI];
  logic       ofs [NI];
  logic [7:0] od  [NI];

  int n_cmp = 0;
  int n_err = 0;

  frame_reorder_buffer #(.WIDTH(8), .DEPTH(4), .INVERT(1'b1)) dut0 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .mode(mode),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[0]), .out_data(od[0]), .frame_start(ofs[0])
  );

  frame_reorder_buffer #(.WIDTH(8), .DEPTH(4), .INVERT(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .mode(mode),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[1]), .out_data(od[1]), .frame_start(ofs[1])
  );

  frame_reorder_buffer #(.WIDTH(8), .DEPTH(3), .INVERT(1'b1)) dut2 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .mode(mode),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[2]), .out_data(od[2]), .frame_start(ofs[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------ reference model
  int         dep [NI] = '{4, 4, 3};
  bit         inv [NI] = '{1'b1, 1'b0, 1'b1};
  logic [7:0] hist [NI][8192];
  bit         fmode [NI][8192];
  int         cnt [NI];
  logic       m_ev [NI];
  logic       m_efs [NI];
  logic [7:0] m_ed [NI];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      cnt[i] = 0; m_ev[i] = 1'b0; m_efs[i] = 1'b0; m_ed[i] = 8'h00;
    end
  endtask

  task automatic model_update(input int i, input logic c, input logic v,
                              input logic m, input logic [7:0] d);
    int k, p, f, src;
    if (c) begin
      cnt[i] = 0; m_ev[i] = 1'b0; m_efs[i] = 1'b0; m_ed[i] = 8'h00;
    end else if (v) begin
      k = cnt[i];
      p = k % dep[i];
      f = k / dep[i];
      if (p == 0) fmode[i][f] = m;
      hist[i][k] = inv[i] ? ~d : d;
      if (f >= 1) begin
        src = (f - 1) * dep[i] + (fmode[i][f] ? (dep[i] - 1 - p) : p);
        m_ed[i]  = hist[i][src];
        m_ev[i]  = 1'b1;
        m_efs[i] = (p == 0);
      end else begin
        m_ev[i]  = 1'b0;
        m_efs[i] = 1'b0;
      end
      cnt[i] = k + 1;
    end else begin
      m_ev[i]  = 1'b0;
      m_efs[i] = 1'b0;
    end
  endtask

  // ------------------------------------------------------------ helpers
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, then check every instance against the model.
  task automatic step(input logic c, input logic v, input logic m, input logic [7:0] d);
    @(negedge clk);
    clear = c; in_valid = v; mode = m; in_data = d;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      model_update(i, c, v, m, d);
      chk($sformatf("model_valid[%0d]", i), {31'd0, ov[i]},  {31'd0, m_ev[i]});
      chk($sformatf("model_fs[%0d]", i),    {31'd0, ofs[i]}, {31'd0, m_efs[i]});
      chk($sformatf("model_data[%0d]", i),  {24'd0, od[i]},  {24'd0, m_ed[i]});
    end
  endtask

  typedef struct {
    logic       c;
    logic       v;
    logic       m;
    logic [7:0] d;
    logic       ev;
    logic       efs;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input logic c, input logic v, input logic m, input logic [7:0] d,
                      input logic ev, input logic efs, input logic [7:0] ed);
    vec_t r;
    r.c = c; r.v = v; r.m = m; r.d = d; r.ev = ev; r.efs = efs; r.ed = ed;
    tbl.push_back(r);
  endtask

  // ------------------------------------------------------------ test
  initial begin
    logic m_r;
    reset_n = 1'b0; clear = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    model_reset();

    // In-order delay, 0x01..0x08.
    for (int i = 1; i <= 4; i++) addv(1'b0, 1'b1, 1'b0, 8'(i), 1'b0, 1'b0, 8'h00);
    addv(1'b0, 1'b1, 1'b0, 8'h05, 1'b1, 1'b1, 8'hFE);
    addv(1'b0, 1'b1, 1'b0, 8'h06, 1'b1, 1'b0, 8'hFD);
    addv(1'b0, 1'b1, 1'b0, 8'h07, 1'b1, 1'b0, 8'hFC);
    addv(1'b0, 1'b1, 1'b0, 8'h08, 1'b1, 1'b0, 8'hFB);
    // Bubbles: data held during gaps.
    addv(1'b0, 1'b1, 1'b0, 8'h09, 1'b1, 1'b1, 8'hFA);
    addv(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFA);
    addv(1'b0, 1'b1, 1'b0, 8'h0A, 1'b1, 1'b0, 8'hF9);
    addv(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hF9);
    addv(1'b0, 1'b1, 1'b0, 8'h0B, 1'b1, 1'b0, 8'hF8);
    addv(1'b0, 1'b1, 1'b0, 8'h0C, 1'b1, 1'b0, 8'hF7);
    // Clear, then frame reversal with 0x10..0x17.
    addv(1'b1, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) addv(1'b0, 1'b1, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 8'h00);
    addv(1'b0, 1'b1, 1'b1, 8'h14, 1'b1, 1'b1, 8'hEC);
    addv(1'b0, 1'b1, 1'b1, 8'h15, 1'b1, 1'b0, 8'hED);
    addv(1'b0, 1'b1, 1'b1, 8'h16, 1'b1, 1'b0, 8'hEE);
    addv(1'b0, 1'b1, 1'b1, 8'h17, 1'b1, 1'b0, 8'hEF);
    // Mode latch: mode rises at wr_idx=2, takes effect on the next frame.
    addv(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) addv(1'b0, 1'b1, 1'b0, 8'(8'h20 + i), 1'b0, 1'b0, 8'h00);
    addv(1'b0, 1'b1, 1'b0, 8'h24, 1'b1, 1'b1, 8'hDF);
    addv(1'b0, 1'b1, 1'b0, 8'h25, 1'b1, 1'b0, 8'hDE);
    addv(1'b0, 1'b1, 1'b1, 8'h26, 1'b1, 1'b0, 8'hDD);
    addv(1'b0, 1'b1, 1'b1, 8'h27, 1'b1, 1'b0, 8'hDC);
    addv(1'b0, 1'b1, 1'b1, 8'h28, 1'b1, 1'b1, 8'hD8);
    addv(1'b0, 1'b1, 1'b1, 8'h29, 1'b1, 1'b0, 8'hD9);
    addv(1'b0, 1'b1, 1'b0, 8'h2A, 1'b1, 1'b0, 8'hDA);
    addv(1'b0, 1'b1, 1'b0, 8'h2B, 1'b1, 1'b0, 8'hDB);
    // Clear after 6 samples; clear with in_valid drops that sample.
    addv(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) addv(1'b0, 1'b1, 1'b0, 8'(8'h30 + i), 1'b0, 1'b0, 8'h00);
    addv(1'b0, 1'b1, 1'b0, 8'h34, 1'b1, 1'b1, 8'hCF);
    addv(1'b0, 1'b1, 1'b0, 8'h35, 1'b1, 1'b0, 8'hCE);
    addv(1'b1, 1'b1, 1'b0, 8'h99, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) addv(1'b0, 1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0, 8'h00);
    addv(1'b0, 1'b1, 1'b0, 8'h44, 1'b1, 1'b1, 8'hBF);
    addv(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hBF);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset_valid[%0d]", i), {31'd0, ov[i]},  32'd0);
      chk($sformatf("reset_fs[%0d]", i),    {31'd0, ofs[i]}, 32'd0);
      chk($sformatf("reset_data[%0d]", i),  {24'd0, od[i]},  32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven vectors.
    for (int r = 0; r < tbl.size(); r++) begin
      step(tbl[r].c, tbl[r].v, tbl[r].m, tbl[r].d);
      chk($sformatf("vec%0d_valid", r), {31'd0, ov[0]},  {31'd0, tbl[r].ev});
      chk($sformatf("vec%0d_fs", r),    {31'd0, ofs[0]}, {31'd0, tbl[r].efs});
      chk($sformatf("vec%0d_data", r),  {24'd0, od[0]},  {24'd0, tbl[r].ed});
    end

    // Randomized traffic against the model.
    m_r = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(15) == 0) m_r = ~m_r;
      step(($urandom_range(63) == 0), ($urandom_range(3) != 0), m_r, 8'($urandom));
    end

    // Asynchronous reset mid-stream, checked before any clock edge.
    step(1'b0, 1'b1, m_r, 8'h5A);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    in_valid = 1'b0;
    clear = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("async_rst_valid[%0d]", i), {31'd0, ov[i]},  32'd0);
      chk($sformatf("async_rst_fs[%0d]", i),    {31'd0, ofs[i]}, 32'd0);
      chk($sformatf("async_rst_data[%0d]", i),  {24'd0, od[i]},  32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < 12; n++) step(1'b0, 1'b1, 1'b0, 8'(8'h60 + n));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
